// File: rtl/ula_scheduler.sv
// Two-requester ALU scheduler: arbitrates, captures operands, computes in EXEC, reports in DONE.
// Optional macro ULA_SCHED_RR_EN selects round-robin arbitration instead of fixed priority to requester 0.
module ula_scheduler #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0,
    input  logic             req1,
    input  logic [2:0]       op0,
    input  logic [2:0]       op1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             ack0,
    output logic             ack1,
    output logic             vld0,
    output logic             vld1,
    output logic [WIDTH-1:0] res,
    output logic             zf,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             any_req;
    logic             grant_id;
    logic             win_id;
    logic [2:0]       op_lat;
    logic [WIDTH-1:0] a_lat;
    logic [WIDTH-1:0] b_lat;
    logic [WIDTH-1:0] alu_res;

    assign any_req = req0 | req1;

`ifdef ULA_SCHED_RR_EN
    // prio names the requester that wins a tie; it flips away from whoever was just granted.
    logic prio;

    always_comb begin
        if (req0 && req1) begin
            grant_id = prio;
        end else begin
            grant_id = req1 & ~req0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prio <= 1'b0;
        end else if (state == IDLE && any_req) begin
            prio <= ~grant_id;
        end
    end
`else
    always_comb begin
        grant_id = ~req0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (any_req) state_next = EXEC;
            EXEC:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The ALU only ever sees captured operands, so requesters may change inputs after ack.
    always_comb begin
        alu_res = '0;
        case (op_lat)
            3'b010:  alu_res = a_lat + b_lat;
            3'b110:  alu_res = a_lat + ~b_lat + {{(WIDTH-1){1'b0}}, 1'b1};
            3'b000:  alu_res = a_lat & b_lat;
            3'b001:  alu_res = a_lat | b_lat;
            3'b111:  alu_res = {{(WIDTH-1){1'b0}}, (a_lat < b_lat)};
            default: alu_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_lat <= 3'b000;
            a_lat  <= '0;
            b_lat  <= '0;
            win_id <= 1'b0;
            res    <= '0;
            zf     <= 1'b1;
        end else begin
            if (state == IDLE && any_req) begin
                win_id <= grant_id;
                op_lat <= grant_id ? op1 : op0;
                a_lat  <= grant_id ? a1 : a0;
                b_lat  <= grant_id ? b1 : b0;
            end
            if (state == EXEC) begin
                res <= alu_res;
                zf  <= (alu_res == '0);
            end
        end
    end

    assign ack0 = (state == EXEC) && !win_id;
    assign ack1 = (state == EXEC) && win_id;
    assign vld0 = (state == DONE) && !win_id;
    assign vld1 = (state == DONE) && win_id;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ula_scheduler.sv
// Directed bench for ula_scheduler: ALU ops, handshake timing, reset abort and arbitration order.
module tb_ula_scheduler;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req0, req1;
    logic [2:0]       op0, op1;
    logic [WIDTH-1:0] a0, b0, a1, b1;
    logic             ack0, ack1, vld0, vld1, zf, busy;
    logic [WIDTH-1:0] res;

    int checks = 0;
    int passes = 0;

    ula_scheduler #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .req1(req1),
        .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .vld0(vld0), .vld1(vld1),
        .res(res), .zf(zf), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            passes++;
        end
    endtask

    // One complete operation; a_late replaces the operand during the ack cycle.
    task automatic applyStimulus(input logic who, input logic [2:0] op,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic [7:0] a_late,
                                 input logic [7:0] exp_res, input logic exp_zf,
                                 input string tag);
        @(negedge clk);
        if (!who) begin
            req0 = 1'b1; req1 = 1'b0; op0 = op; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; req0 = 1'b0; op1 = op; a1 = a; b1 = b;
        end
        @(negedge clk);
        checkOutput({tag, "_ack"},   32'(who ? ack1 : ack0), 32'd1);
        checkOutput({tag, "_nack"},  32'(who ? ack0 : ack1), 32'd0);
        checkOutput({tag, "_busy"},  32'(busy), 32'd1);
        req0 = 1'b0; req1 = 1'b0;
        if (!who) a0 = a_late; else a1 = a_late;
        @(negedge clk);
        checkOutput({tag, "_vld"},   32'(who ? vld1 : vld0), 32'd1);
        checkOutput({tag, "_nvld"},  32'(who ? vld0 : vld1), 32'd0);
        checkOutput({tag, "_res"},   32'(res), 32'(exp_res));
        checkOutput({tag, "_zf"},    32'(zf), 32'(exp_zf));
        @(negedge clk);
        checkOutput({tag, "_vldoff"}, 32'(vld0 | vld1), 32'd0);
        checkOutput({tag, "_idle"},  32'(busy), 32'd0);
        checkOutput({tag, "_hold"},  32'(res), 32'(exp_res));
    endtask

    initial begin
        int exp_win;
        rst_n = 1'b0; req0 = 1'b0; req1 = 1'b0;
        op0 = 3'b000; op1 = 3'b000; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        repeat (2) @(negedge clk);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_res",  32'(res), 32'd0);
        checkOutput("rst_zf",   32'(zf), 32'd1);
        checkOutput("rst_ack",  32'({ack0, ack1}), 32'd0);
        checkOutput("rst_vld",  32'({vld0, vld1}), 32'd0);
        rst_n = 1'b1;

        applyStimulus(1'b0, 3'b010, 8'h0F, 8'h01, 8'h0F, 8'h10, 1'b0, "add");
        applyStimulus(1'b1, 3'b110, 8'h05, 8'h05, 8'h05, 8'h00, 1'b1, "sub");
        applyStimulus(1'b1, 3'b111, 8'h03, 8'h09, 8'h03, 8'h01, 1'b0, "slt");
        applyStimulus(1'b0, 3'b111, 8'h09, 8'h03, 8'h09, 8'h00, 1'b1, "sltn");
        applyStimulus(1'b0, 3'b011, 8'h05, 8'h07, 8'h05, 8'h00, 1'b1, "bad");
        applyStimulus(1'b1, 3'b000, 8'hF0, 8'h3C, 8'hF0, 8'h30, 1'b0, "and");
        applyStimulus(1'b0, 3'b010, 8'hFF, 8'h01, 8'hFF, 8'h00, 1'b1, "wrap");
        applyStimulus(1'b0, 3'b001, 8'hFF, 8'h00, 8'h00, 8'hFF, 1'b0, "late");

        // Reset while in EXEC must abort with no vld.
        @(negedge clk);
        req0 = 1'b1; op0 = 3'b010; a0 = 8'h01; b0 = 8'h01;
        @(negedge clk);
        checkOutput("abt_ack", 32'(ack0), 32'd1);
        rst_n = 1'b0; req0 = 1'b0;
        @(negedge clk);
        checkOutput("abt_busy", 32'(busy), 32'd0);
        checkOutput("abt_vld",  32'({vld0, vld1}), 32'd0);
        checkOutput("abt_res",  32'(res), 32'd0);
        checkOutput("abt_zf",   32'(zf), 32'd1);
        rst_n = 1'b1;
        req1 = 1'b1; op1 = 3'b000; a1 = 8'h0F; b1 = 8'hFF;
        @(negedge clk);
        checkOutput("post_ack1", 32'(ack1), 32'd1);
        checkOutput("post_vld",  32'({vld0, vld1}), 32'd0);
        req1 = 1'b0;
        @(negedge clk);
        checkOutput("post_vld1", 32'(vld1), 32'd1);
        checkOutput("post_res",  32'(res), 32'h0F);

        // Both requesters held high for six operations from a fresh reset.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req0 = 1'b1; op0 = 3'b010; a0 = 8'h01; b0 = 8'h01;
        req1 = 1'b1; op1 = 3'b001; a1 = 8'h40; b1 = 8'h01;
        for (int i = 0; i < 6; i++) begin
`ifdef ULA_SCHED_RR_EN
            exp_win = i % 2;
`else
            exp_win = 0;
`endif
            @(negedge clk);
            checkOutput($sformatf("arb%0d_ack0", i), 32'(ack0), 32'(exp_win == 0));
            checkOutput($sformatf("arb%0d_ack1", i), 32'(ack1), 32'(exp_win == 1));
            @(negedge clk);
            checkOutput($sformatf("arb%0d_res", i), 32'(res), (exp_win == 1) ? 32'h41 : 32'h02);
            @(negedge clk);
        end
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
